data_modulate_3x3_ctrl: RTL and testbench

//   Sequencing controller for the 3x3 window datapath of the Data_modulate stage.

---
 rtl/data_modulate_3x3_ctrl.sv | 132 +++++++++++++
 tb/tb_data_modulate_3x3_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_modulate_3x3_ctrl.sv
// Sequencing controller for the Data_modulate 3x3 window datapath.
// Paces column beats into the window, adds one flush shift per row and tracks window position.
module data_modulate_3x3_ctrl #(
    parameter int ROWS = 480,
    parameter int COLS = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       shift_en_o,
    output logic       win_valid_o,
    input  logic       out_ready_i,
    output logic [9:0] win_row_o,
    output logic [9:0] win_col_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    // state | meaning
    // IDLE  | waiting for frame_start_i
    // FILL  | first beat of a row: primes the window, no window produced
    // RUN   | each accepted beat produces the window one column behind
    // FLUSH | input-less shift that produces the last column of the row
    // DONE  | last window outstanding; pulse frame_done_o once it is gone
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [9:0] LAST_COL = 10'(COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(ROWS - 1);

    state_t     r_state;
    logic [9:0] r_row;
    logic [9:0] r_in_col;
    logic       r_win_valid;
    logic [9:0] r_win_row;
    logic [9:0] r_win_col;
    logic       r_frame_done;

    logic w_adv;
    logic w_in_phase;
    logic w_accept;
    logic w_flush_shift;
    logic w_produce;

    // The window slot is free when empty or being taken this cycle.
    assign w_adv         = ~r_win_valid | out_ready_i;
    assign w_in_phase    = (r_state == S_FILL) | (r_state == S_RUN);
    assign w_accept      = w_in_phase & w_adv & in_valid_i;
    assign w_flush_shift = (r_state == S_FLUSH) & w_adv;
    assign w_produce     = ((r_state == S_RUN) & w_accept) | w_flush_shift;

    assign in_ready_o   = w_in_phase & w_adv;
    assign shift_en_o   = w_accept | w_flush_shift;
    assign win_valid_o  = r_win_valid;
    assign win_row_o    = r_win_row;
    assign win_col_o    = r_win_col;
    assign busy_o       = (r_state != S_IDLE);
    assign frame_done_o = r_frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_in_col     <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_produce) begin
                r_win_valid <= 1'b1;
                r_win_row   <= r_row;
                r_win_col   <= (r_state == S_FLUSH) ? LAST_COL : (r_in_col - 10'd1);
            end else if (out_ready_i) begin
                r_win_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start_i) begin
                        r_row    <= '0;
                        r_in_col <= '0;
                        r_state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_in_col <= 10'd1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_in_col == LAST_COL) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_in_col <= r_in_col + 10'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_adv) begin
                        if (r_row == LAST_ROW) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row    <= r_row + 10'd1;
                            r_in_col <= '0;
                            r_state  <= S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    if (w_adv) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_modulate_3x3_ctrl.sv
// Scoreboard bench for data_modulate_3x3_ctrl: raster-order window model, a 4x5 and a 2x2 instance.
module tb_data_modulate_3x3_ctrl;

    localparam int AR = 4;
    localparam int AC = 5;
    localparam int BR = 2;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_start = 0, a_in_valid = 0, a_out_ready = 0;
    logic       a_in_ready, a_shift, a_win_valid, a_busy, a_frame_done;
    logic [9:0] a_row, a_col;
    logic       b_start = 0, b_in_valid = 0, b_out_ready = 0;
    logic       b_in_ready, b_shift, b_win_valid, b_busy, b_frame_done;
    logic [9:0] b_row, b_col;

    always #5 clk = ~clk;

    data_modulate_3x3_ctrl #(.ROWS(AR), .COLS(AC)) u_dut_a (
        .clk(clk), .rst(rst), .frame_start_i(a_start), .in_valid_i(a_in_valid),
        .in_ready_o(a_in_ready), .shift_en_o(a_shift), .win_valid_o(a_win_valid),
        .out_ready_i(a_out_ready), .win_row_o(a_row), .win_col_o(a_col),
        .busy_o(a_busy), .frame_done_o(a_frame_done)
    );

    data_modulate_3x3_ctrl #(.ROWS(BR), .COLS(BC)) u_dut_b (
        .clk(clk), .rst(rst), .frame_start_i(b_start), .in_valid_i(b_in_valid),
        .in_ready_o(b_in_ready), .shift_en_o(b_shift), .win_valid_o(b_win_valid),
        .out_ready_i(b_out_ready), .win_row_o(b_row), .win_col_o(b_col),
        .busy_o(b_busy), .frame_done_o(b_frame_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [19:0] exp_a[$];
    logic [19:0] obs_a[$];
    logic [19:0] exp_b[$];
    logic [19:0] obs_b[$];

    int a_shifts = 0, a_accepts = 0, a_dones = 0, a_last_acc = 0, a_done_cyc = 0;
    int b_shifts = 0, b_dones = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_shift) a_shifts++;
            if (a_in_valid && a_in_ready) a_accepts++;
            if (a_win_valid && a_out_ready) begin
                obs_a.push_back({a_row, a_col});
                a_last_acc = cyc;
            end
            if (a_frame_done) begin
                a_dones++;
                a_done_cyc = cyc;
            end
            if (b_shift) b_shifts++;
            if (b_win_valid && b_out_ready) obs_b.push_back({b_row, b_col});
            if (b_frame_done) b_dones++;
        end
    end

    task automatic push_exp(input bit sel_b, input int rows, input int cols);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                if (sel_b) exp_b.push_back({10'(r), 10'(c)});
                else exp_a.push_back({10'(r), 10'(c)});
    endtask

    // Drives DUT A cycle by cycle; returns on frame_done, on reaching window (stop_r,stop_c), or on timeout.
    task automatic drive_a(input bit toggle, input bit start, input int stop_r, input int stop_c,
                           input int rs_r, input int rs_c, output bit hit, output bit timeout);
        bit restarted = 0;
        hit = 0;
        timeout = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (a_frame_done) begin
                timeout = 0;
                a_start = 0;
                return;
            end
            if (a_win_valid && int'(a_row) == stop_r && int'(a_col) == stop_c) begin
                hit = 1;
                timeout = 0;
                a_start = 0;
                return;
            end
            a_start = (start && i == 0);
            if (!restarted && a_win_valid && int'(a_row) == rs_r && int'(a_col) == rs_c) begin
                a_start = 1;
                restarted = 1;
            end
            if (toggle) a_in_valid = ~a_in_valid;
        end
        a_start = 0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({a_in_ready, a_shift, a_win_valid, a_busy, a_frame_done, a_row, a_col} !== 25'd0) begin
            fails++;
            $display("FAIL reset_a: got %h want 0", {a_in_ready, a_shift, a_win_valid, a_busy, a_frame_done, a_row, a_col});
        end
        tests++;
        if ({b_in_ready, b_shift, b_win_valid, b_busy, b_frame_done, b_row, b_col} !== 25'd0) begin
            fails++;
            $display("FAIL reset_b: got %h want 0", {b_in_ready, b_shift, b_win_valid, b_busy, b_frame_done, b_row, b_col});
        end
        @(negedge clk);
        rst = 0;
        a_in_valid = 1;
        a_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({a_in_ready, a_shift, a_busy} !== 3'b000 || a_accepts !== 0) begin
            fails++;
            $display("FAIL idle_ignores_input: got rdy/shift/busy=%b accepts=%0d want 000/0",
                     {a_in_ready, a_shift, a_busy}, a_accepts);
        end
    endtask

    task automatic test_full_frame();
        int s0 = a_shifts, ac0 = a_accepts, d0 = a_dones;
        bit hit, to;
        logic [19:0] e, o;
        push_exp(0, AR, AC);
        a_in_valid = 1;
        a_out_ready = 1;
        drive_a(0, 1, -1, -1, -1, -1, hit, to);
        tests++;
        if (to) begin fails++; $display("FAIL full_timeout: got no frame_done want frame_done"); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_shifts - s0 !== 24) begin fails++; $display("FAIL full_shifts: got %0d want 24", a_shifts - s0); end
        tests++;
        if (a_accepts - ac0 !== 20) begin fails++; $display("FAIL full_accepts: got %0d want 20", a_accepts - ac0); end
        tests++;
        if (a_dones - d0 !== 1) begin fails++; $display("FAIL full_done_count: got %0d want 1", a_dones - d0); end
        tests++;
        if (a_done_cyc - a_last_acc !== 1) begin
            fails++;
            $display("FAIL full_done_latency: got %0d want 1", a_done_cyc - a_last_acc);
        end
        tests++;
        if (a_busy !== 1'b0) begin fails++; $display("FAIL full_busy_after: got %b want 0", a_busy); end
        tests++;
        if (obs_a.size() !== exp_a.size()) begin
            fails++;
            $display("FAIL full_win_count: got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front();
            o = obs_a.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL full_win: got (%0d,%0d) want (%0d,%0d)", o[19:10], o[9:0], e[19:10], e[9:0]);
            end
        end
        exp_a.delete();
        obs_a.delete();
    endtask

    task automatic test_stall();
        int s0 = a_shifts, d0 = a_dones;
        bit hit, to;
        logic [19:0] e, o;
        push_exp(0, AR, AC);
        a_in_valid = 1;
        a_out_ready = 1;
        drive_a(0, 1, 1, 2, -1, -1, hit, to);
        tests++;
        if (!hit) begin fails++; $display("FAIL stall_reach: got no window (1,2) want window (1,2)"); end
        a_out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if ({a_in_ready, a_shift, a_win_valid, a_row, a_col} !== {1'b0, 1'b0, 1'b1, 10'd1, 10'd2}) begin
                fails++;
                $display("FAIL stall_hold: got rdy=%b shift=%b vld=%b (%0d,%0d) want rdy=0 shift=0 vld=1 (1,2)",
                         a_in_ready, a_shift, a_win_valid, a_row, a_col);
            end
            @(posedge clk);
        end
        #1;
        a_out_ready = 1;
        drive_a(0, 0, -1, -1, -1, -1, hit, to);
        tests++;
        if (to) begin fails++; $display("FAIL stall_timeout: got no frame_done want frame_done"); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_shifts - s0 !== 24 || a_dones - d0 !== 1) begin
            fails++;
            $display("FAIL stall_counts: got shifts=%0d dones=%0d want 24/1", a_shifts - s0, a_dones - d0);
        end
        tests++;
        if (obs_a.size() !== exp_a.size()) begin
            fails++;
            $display("FAIL stall_win_count: got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front();
            o = obs_a.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL stall_win: got (%0d,%0d) want (%0d,%0d)", o[19:10], o[9:0], e[19:10], e[9:0]);
            end
        end
        exp_a.delete();
        obs_a.delete();
    endtask

    task automatic test_toggle_valid();
        int s0 = a_shifts, ac0 = a_accepts;
        bit hit, to;
        logic [19:0] e, o;
        push_exp(0, AR, AC);
        a_in_valid = 1;
        a_out_ready = 1;
        drive_a(1, 1, -1, -1, -1, -1, hit, to);
        tests++;
        if (to) begin fails++; $display("FAIL toggle_timeout: got no frame_done want frame_done"); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_shifts - s0 !== 24 || a_accepts - ac0 !== 20) begin
            fails++;
            $display("FAIL toggle_counts: got shifts=%0d accepts=%0d want 24/20", a_shifts - s0, a_accepts - ac0);
        end
        tests++;
        if (obs_a.size() !== exp_a.size()) begin
            fails++;
            $display("FAIL toggle_win_count: got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front();
            o = obs_a.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL toggle_win: got (%0d,%0d) want (%0d,%0d)", o[19:10], o[9:0], e[19:10], e[9:0]);
            end
        end
        exp_a.delete();
        obs_a.delete();
        a_in_valid = 1;
    endtask

    task automatic test_restart_ignored();
        int s0 = a_shifts, d0 = a_dones;
        bit hit, to;
        logic [19:0] e, o;
        push_exp(0, AR, AC);
        a_in_valid = 1;
        a_out_ready = 1;
        drive_a(0, 1, -1, -1, 2, 1, hit, to);
        tests++;
        if (to) begin fails++; $display("FAIL restart_timeout: got no frame_done want frame_done"); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_shifts - s0 !== 24 || a_dones - d0 !== 1 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL restart_counts: got shifts=%0d dones=%0d busy=%b want 24/1/0",
                     a_shifts - s0, a_dones - d0, a_busy);
        end
        tests++;
        if (obs_a.size() !== exp_a.size()) begin
            fails++;
            $display("FAIL restart_win_count: got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front();
            o = obs_a.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL restart_win: got (%0d,%0d) want (%0d,%0d)", o[19:10], o[9:0], e[19:10], e[9:0]);
            end
        end
        exp_a.delete();
        obs_a.delete();
    endtask

    task automatic test_mid_reset();
        int s0, d0;
        bit hit, to;
        logic [19:0] e, o;
        a_in_valid = 1;
        a_out_ready = 1;
        drive_a(0, 1, 1, 3, -1, -1, hit, to);
        tests++;
        if (!hit) begin fails++; $display("FAIL rst_reach: got no window (1,3) want window (1,3)"); end
        d0 = a_dones;
        #2;
        rst = 1;
        #1;
        tests++;
        if ({a_in_ready, a_shift, a_win_valid, a_busy, a_frame_done, a_row, a_col} !== 25'd0) begin
            fails++;
            $display("FAIL rst_async: got %h want 0", {a_in_ready, a_shift, a_win_valid, a_busy, a_frame_done, a_row, a_col});
        end
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_dones !== d0 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_done: got dones=%0d busy=%b want %0d/0", a_dones, a_busy, d0);
        end
        exp_a.delete();
        obs_a.delete();
        s0 = a_shifts;
        d0 = a_dones;
        push_exp(0, AR, AC);
        drive_a(0, 1, -1, -1, -1, -1, hit, to);
        tests++;
        if (to) begin fails++; $display("FAIL rst_next_timeout: got no frame_done want frame_done"); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_shifts - s0 !== 24 || a_dones - d0 !== 1) begin
            fails++;
            $display("FAIL rst_next_counts: got shifts=%0d dones=%0d want 24/1", a_shifts - s0, a_dones - d0);
        end
        tests++;
        if (obs_a.size() !== exp_a.size()) begin
            fails++;
            $display("FAIL rst_next_win_count: got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front();
            o = obs_a.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL rst_next_win: got (%0d,%0d) want (%0d,%0d)", o[19:10], o[9:0], e[19:10], e[9:0]);
            end
        end
        exp_a.delete();
        obs_a.delete();
    endtask

    task automatic test_small_frame();
        int s0 = b_shifts, d0 = b_dones;
        bit done = 0;
        logic [19:0] e, o;
        push_exp(1, BR, BC);
        b_in_valid = 1;
        b_out_ready = 1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
            b_start = (i == 0);
            if (b_frame_done) done = 1;
        end
        b_start = 0;
        tests++;
        if (!done) begin fails++; $display("FAIL small_timeout: got no frame_done want frame_done"); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (b_shifts - s0 !== 6 || b_dones - d0 !== 1) begin
            fails++;
            $display("FAIL small_counts: got shifts=%0d dones=%0d want 6/1", b_shifts - s0, b_dones - d0);
        end
        tests++;
        if (obs_b.size() !== exp_b.size()) begin
            fails++;
            $display("FAIL small_win_count: got %0d want %0d", obs_b.size(), exp_b.size());
        end
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            e = exp_b.pop_front();
            o = obs_b.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL small_win: got (%0d,%0d) want (%0d,%0d)", o[19:10], o[9:0], e[19:10], e[9:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_toggle_valid();
        test_restart_ignored();
        test_mid_reset();
        test_small_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
